// File: rtl/sw_debounce_if.sv
// Switch conditioner bus: raw pins and W1C write strobe in,
// debounced state and sticky change flags out.
interface sw_debounce_if #(
  parameter int unsigned NUM_SW = 10
);
  logic [NUM_SW-1:0] sw_i;
  logic              clr_we_i;
  logic [NUM_SW-1:0] clr_mask_i;
  logic [NUM_SW-1:0] sw_o;
  logic [NUM_SW-1:0] changed_o;
  logic              any_changed_o;

  modport master (
    output sw_i, clr_we_i, clr_mask_i,
    input  sw_o, changed_o, any_changed_o
  );

  modport slave (
    input  sw_i, clr_we_i, clr_mask_i,
    output sw_o, changed_o, any_changed_o
  );
endinterface

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit 2-flop synchronizer, debounce counter and
// sticky W1C change flag; feeds the 0xC001 switch read.
module sw_debounce_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  input  logic clr_i,
  output logic sw_o,
  output logic changed_o
);
  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 sw_q, sw_d;
  logic                 chg_q, chg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;

  // The counter only runs while sync2 disagrees with the accepted level,
  // so it is bounded by CNT_LAST and never wraps.
  always_comb begin
    cnt_d  = cnt_q;
    sw_d   = sw_q;
    accept = 1'b0;
    if (sync2_q == sw_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      sw_d   = sync2_q;
      cnt_d  = '0;
      accept = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Set dominates clear so an acceptance coinciding with a W1C write is kept.
  assign chg_d = accept | (chg_q & ~clr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sw_q    <= 1'b0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      sw_q    <= sw_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_o      = sw_q;
  assign changed_o = chg_q;
endmodule

module sw_debounce #(
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic          clk,
  input  logic          rst_n,
  sw_debounce_if.slave  bus
);
  logic [NUM_SW-1:0] sw_vec;
  logic [NUM_SW-1:0] chg_vec;
  logic [NUM_SW-1:0] clr_vec;

  assign clr_vec = bus.clr_mask_i & {NUM_SW{bus.clr_we_i}};

  for (genvar g = 0; g < NUM_SW; g++) begin : g_lane
    sw_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_i      (bus.sw_i[g]),
      .clr_i     (clr_vec[g]),
      .sw_o      (sw_vec[g]),
      .changed_o (chg_vec[g])
    );
  end

  // OR of flop outputs only, so the summary flag is glitch-free.
  assign bus.sw_o          = sw_vec;
  assign bus.changed_o     = chg_vec;
  assign bus.any_changed_o = |chg_vec;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4 and a queue of
// expected per-edge outputs.
module tb_sw_debounce;
  localparam int unsigned N = 10;
  localparam int unsigned D = 4;

  typedef struct {
    string        tag;
    logic [N-1:0] sw;
    logic [N-1:0] chg;
    logic         any;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  sw_debounce_if #(.NUM_SW(N)) bus ();

  sw_debounce #(.NUM_SW(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [N-1:0] sw, input logic [N-1:0] chg,
                      input int n = 1);
    exp_t e;
    e.tag = tag;
    e.sw  = sw;
    e.chg = chg;
    e.any = |chg;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      assert (0) else begin
        errors++;
        $error("FAIL scoreboard_empty observed=none expected=entry");
      end
    end else begin
      e = exp_q.pop_front();
      checks += 3;
      assert (bus.sw_o === e.sw) else begin
        errors++;
        $error("FAIL %s sw_o observed=%h expected=%h", e.tag, bus.sw_o, e.sw);
      end
      assert (bus.changed_o === e.chg) else begin
        errors++;
        $error("FAIL %s changed_o observed=%h expected=%h", e.tag, bus.changed_o, e.chg);
      end
      assert (bus.any_changed_o === e.any) else begin
        errors++;
        $error("FAIL %s any_changed_o observed=%b expected=%b", e.tag, bus.any_changed_o, e.any);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_now();
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.sw_i       = 10'h3FF;
    bus.clr_we_i   = 1'b0;
    bus.clr_mask_i = '0;

    // Reset sanity with all switches high
    tick(); tick();
    push("in_reset", '0, '0);
    check_now();
    rst_n = 1'b1;
    push("boot_wait", '0, '0, D + 1);
    push("boot_accept", 10'h3FF, 10'h3FF);
    run(D + 2);

    // Mask ignored without strobe, zero mask with strobe, full clear
    bus.clr_mask_i = 10'h3FF;
    push("no_we", 10'h3FF, 10'h3FF);
    run(1);
    bus.clr_we_i = 1'b1; bus.clr_mask_i = 10'h000;
    push("mask_zero", 10'h3FF, 10'h3FF);
    run(1);
    bus.clr_mask_i = 10'h3FF;
    push("clr_all", 10'h3FF, 10'h000);
    run(1);
    bus.clr_we_i = 1'b0;

    // Reset with switches low to settle at zero
    bus.sw_i = '0;
    rst_n = 1'b0;
    #1;
    push("rst_zero", '0, '0);
    check_now();
    tick();
    rst_n = 1'b1;
    push("settle_zero", '0, '0, D + 4);
    run(D + 4);

    // Clean transition on bit 3
    bus.sw_i = 10'h008;
    push("clean_wait", '0, '0, D + 1);
    push("clean_accept", 10'h008, 10'h008);
    run(D + 2);
    bus.clr_we_i = 1'b1; bus.clr_mask_i = 10'h3FF;
    push("clean_clr", 10'h008, '0);
    run(1);
    bus.clr_we_i = 1'b0;

    // 3-cycle glitch on bit 5 is rejected
    bus.sw_i = 10'h028;
    push("glitch3_hi", 10'h008, '0, 3);
    run(3);
    bus.sw_i = 10'h008;
    push("glitch3_after", 10'h008, '0, 7);
    run(7);

    // 4-cycle pulse on bit 5 is accepted, then its fall is accepted too
    bus.sw_i = 10'h028;
    push("pulse4_hi", 10'h008, '0, 4);
    run(4);
    bus.sw_i = 10'h008;
    push("pulse4_wait", 10'h008, '0);
    push("pulse4_rise", 10'h028, 10'h020, 4);
    push("pulse4_fall", 10'h008, 10'h020);
    run(6);
    bus.clr_we_i = 1'b1; bus.clr_mask_i = 10'h3FF;
    push("pulse4_clr", 10'h008, '0);
    run(1);
    bus.clr_we_i = 1'b0;

    // Bits 2 (rise) and 3 (fall) accept together, then partial W1C
    bus.sw_i = 10'h004;
    push("dual_wait", 10'h008, '0, D + 1);
    push("dual_accept", 10'h004, 10'h00C);
    run(D + 2);
    bus.clr_we_i = 1'b1; bus.clr_mask_i = 10'h004;
    push("w1c_bit2", 10'h004, 10'h008);
    run(1);
    bus.clr_mask_i = 10'h000;
    push("w1c_zero", 10'h004, 10'h008);
    run(1);
    bus.clr_we_i = 1'b0; bus.clr_mask_i = 10'h3FF;
    push("w1c_no_we", 10'h004, 10'h008);
    run(1);
    bus.clr_we_i = 1'b1;
    push("w1c_all", 10'h004, '0);
    run(1);
    bus.clr_we_i = 1'b0;

    // Clear of bit 0 on the same edge bit 0 accepts: set wins
    bus.sw_i = 10'h005;
    push("coll_wait", 10'h004, '0, D + 1);
    run(D + 1);
    bus.clr_we_i = 1'b1; bus.clr_mask_i = 10'h001;
    push("coll_edge", 10'h005, 10'h001);
    run(1);
    bus.clr_we_i = 1'b0;
    push("coll_hold", 10'h005, 10'h001);
    run(1);
    bus.clr_we_i = 1'b1; bus.clr_mask_i = 10'h3FF;
    push("coll_clr", 10'h005, '0);
    run(1);
    bus.clr_we_i = 1'b0;

    // Reset mid-count on bit 7
    bus.sw_i = 10'h085;
    push("mid_count", 10'h005, '0, 4);
    run(4);
    rst_n = 1'b0;
    #1;
    push("mid_rst_async", '0, '0);
    check_now();
    tick();
    push("mid_rst_hold", '0, '0);
    check_now();
    rst_n = 1'b1;
    push("mid_restart_wait", '0, '0, D + 1);
    push("mid_restart_accept", 10'h085, 10'h085);
    run(D + 2);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
